// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: valid/ready word input, LSB-first serial frame
// with optional parity and 1-2 stop bits, internal baud divider, registered txd.
module uart_tx_frame #(
    parameter int CLK_DIV   = 434,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic                 txd,
    output logic                 busy
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
    localparam logic [CW-1:0] BAUD_ZERO = CW'(0);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [BW-1:0] BIT_ZERO  = BW'(0);
    localparam logic          STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    generate
        if (CLK_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
            STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
            $error("uart_tx_frame: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Parity bit sent after the data: odd makes the total count of ones odd.
    function automatic logic frame_parity(input logic [DATA_BITS-1:0] word);
        if (PARITY == 1) begin
            frame_parity = ~^word;
        end else begin
            frame_parity = ^word;
        end
    endfunction

    state_t                 state_q, state_d;
    logic [CW-1:0]          baud_q, baud_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   stop_q, stop_d;
    logic                   txd_q, txd_d;
    logic                   busy_q, busy_d;
    logic                   boundary_s;

    assign boundary_s = (baud_q == BAUD_LAST);
    assign din_ready  = (state_q == S_IDLE);
    assign txd        = txd_q;
    assign busy       = busy_q;

    // Next-state logic; txd_d is the line level for the cycle after this edge.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        stop_d  = stop_q;
        txd_d   = txd_q;
        case (state_q)
            S_IDLE: begin
                baud_d = BAUD_ZERO;
                if (din_valid) begin
                    state_d = S_START;
                    shift_d = din;
                    par_d   = frame_parity(din);
                    bit_d   = BIT_ZERO;
                    stop_d  = 1'b0;
                    txd_d   = 1'b0;
                end else begin
                    txd_d = 1'b1;
                end
            end
            S_START: begin
                if (boundary_s) begin
                    state_d = S_DATA;
                    baud_d  = BAUD_ZERO;
                    txd_d   = shift_q[0];
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            S_DATA: begin
                if (boundary_s) begin
                    baud_d = BAUD_ZERO;
                    if (bit_q == BIT_LAST) begin
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            txd_d   = par_q;
                        end else begin
                            state_d = S_STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + BIT_ONE;
                        shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                        txd_d   = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            S_PARITY: begin
                if (boundary_s) begin
                    state_d = S_STOP;
                    baud_d  = BAUD_ZERO;
                    txd_d   = 1'b1;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            S_STOP: begin
                if (boundary_s) begin
                    baud_d = BAUD_ZERO;
                    if (stop_q == STOP_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        stop_d = 1'b1;
                    end
                    txd_d = 1'b1;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = BAUD_ZERO;
                txd_d   = 1'b1;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset drops any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= BAUD_ZERO;
            bit_q   <= BIT_ZERO;
            shift_q <= {DATA_BITS{1'b0}};
            par_q   <= 1'b0;
            stop_q  <= 1'b0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            stop_q  <= stop_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: 8N1, 7E2 and 7O2 instances at CLK_DIV=4,
// per-cycle txd/busy checks and a receiver model on the 8N1 line.
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din_a;
    logic       valid_a, ready_a, txd_a, busy_a;
    logic [6:0] din_bc;
    logic       valid_b, ready_b, txd_b, busy_b;
    logic       valid_c, ready_c, txd_c, busy_c;
    int         tests = 0;
    int         fails = 0;

    logic       rx_active = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_shift = 8'h00;
    logic [8:0] rx_q[$];

    always #5 clk = ~clk;

    uart_tx_frame #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst(rst), .din(din_a), .din_valid(valid_a),
        .din_ready(ready_a), .txd(txd_a), .busy(busy_a));

    uart_tx_frame #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_b (
        .clk(clk), .rst(rst), .din(din_bc), .din_valid(valid_b),
        .din_ready(ready_b), .txd(txd_b), .busy(busy_b));

    uart_tx_frame #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_c (
        .clk(clk), .rst(rst), .din(din_bc), .din_valid(valid_c),
        .din_ready(ready_c), .txd(txd_c), .busy(busy_c));

    // Receiver for the 8N1 line: samples mid-bit, 2 cycles into each 4-cycle bit.
    always @(posedge clk) begin
        if (rst) begin
            rx_active <= 1'b0;
        end else if (!rx_active) begin
            if (txd_a === 1'b0) begin
                rx_active <= 1'b1;
                rx_cnt    <= 1;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt % 4 == 2) begin
                if (rx_cnt / 4 >= 1 && rx_cnt / 4 <= 8) begin
                    rx_shift[rx_cnt / 4 - 1] <= txd_a;
                end else if (rx_cnt / 4 == 9) begin
                    rx_q.push_back({txd_a, rx_shift});
                    rx_active <= 1'b0;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_txd(input int sel);
        return (sel == 0) ? txd_a : (sel == 1) ? txd_b : txd_c;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
    endfunction

    function automatic logic get_ready(input int sel);
        return (sel == 0) ? ready_a : (sel == 1) ? ready_b : ready_c;
    endfunction

    task automatic set_valid(input int sel, input logic v);
        if (sel == 0) valid_a = v;
        else if (sel == 1) valid_b = v;
        else valid_c = v;
    endtask

    // Checks txd and busy every cycle; starts on the first start-bit cycle.
    task automatic run_bits(input int sel, input logic [15:0] bits, input int nbits, input string tag);
        for (int i = 0; i < nbits * 4; i++) begin
            chk($sformatf("%s txd c%0d", tag, i), get_txd(sel), bits[i / 4]);
            chk($sformatf("%s busy c%0d", tag, i), get_busy(sel), 1'b1);
            tick();
        end
    endtask

    task automatic idle_check(input int sel, input string tag);
        chk({tag, " idle txd"}, get_txd(sel), 1'b1);
        chk({tag, " idle busy"}, get_busy(sel), 1'b0);
        chk({tag, " idle ready"}, get_ready(sel), 1'b1);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] word, input logic [15:0] bits,
                              input int nbits, input string tag);
        chk({tag, " ready"}, get_ready(sel), 1'b1);
        if (sel == 0) din_a = word;
        else din_bc = word[6:0];
        set_valid(sel, 1'b1);
        tick();
        set_valid(sel, 1'b0);
        run_bits(sel, bits, nbits, tag);
        idle_check(sel, tag);
    endtask

    initial begin
        logic [7:0] exp_words [5];
        exp_words[0] = 8'hA5;
        exp_words[1] = 8'h00;
        exp_words[2] = 8'hFF;
        exp_words[3] = 8'h3C;
        exp_words[4] = 8'h5A;

        // Reset with din_valid high: line idle, nothing accepted.
        rst = 1'b1; valid_a = 1'b1; valid_b = 1'b1; valid_c = 1'b1;
        din_a = 8'hFF; din_bc = 7'h7F;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rst txd_a %0d", i), txd_a, 1'b1);
            chk($sformatf("rst busy_a %0d", i), busy_a, 1'b0);
            chk($sformatf("rst txd_b %0d", i), txd_b, 1'b1);
        end
        rst = 1'b0; valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
        chk("post-rst ready", ready_a, 1'b1);
        tick();
        idle_check(0, "post-rst");

        // 8N1 0xA5.
        send_frame(0, 8'hA5, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, "8N1");

        // 7E2 and 7O2 with 0x53 (four ones): parity 0 and 1, 44-cycle frames.
        send_frame(1, 8'h53, {5'b0, 1'b1, 1'b1, 1'b0, 7'h53, 1'b0}, 11, "7E2");
        send_frame(2, 8'h53, {5'b0, 1'b1, 1'b1, 1'b1, 7'h53, 1'b0}, 11, "7O2");

        // Back-to-back with din_valid held: exactly one idle cycle between frames.
        din_a = 8'h00; valid_a = 1'b1;
        chk("b2b ready0", ready_a, 1'b1);
        tick();
        din_a = 8'hFF;
        run_bits(0, {6'b0, 1'b1, 8'h00, 1'b0}, 10, "b2b0");
        chk("b2b gap txd", txd_a, 1'b1);
        chk("b2b gap ready", ready_a, 1'b1);
        tick();
        valid_a = 1'b0;
        run_bits(0, {6'b0, 1'b1, 8'hFF, 1'b0}, 10, "b2b1");
        idle_check(0, "b2b");

        // Reset during data bit 3 of 0xF7 (bit 3 is 0), then a clean 0x3C frame.
        din_a = 8'hF7; valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        for (int i = 0; i < 17; i++) tick();
        chk("abort bit3 txd", txd_a, 1'b0);
        rst = 1'b1;
        tick();
        chk("abort txd", txd_a, 1'b1);
        chk("abort busy", busy_a, 1'b0);
        chk("abort ready", ready_a, 1'b1);
        rst = 1'b0;
        tick();
        send_frame(0, 8'h3C, {6'b0, 1'b1, 8'h3C, 1'b0}, 10, "post-abort");

        // din_valid pulses and din changes mid-frame must not disturb 0x5A.
        din_a = 8'h5A; valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 10) begin din_a = 8'hC3; valid_a = 1'b1; end
            else if (i == 30) begin din_a = 8'h81; valid_a = 1'b1; end
            else valid_a = 1'b0;
            chk($sformatf("holdoff txd c%0d", i), txd_a, ((i / 4) == 0) ? 1'b0 :
                ((i / 4) == 9) ? 1'b1 : exp_words[4][i / 4 - 1]);
            tick();
        end
        valid_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("holdoff quiet txd %0d", i), txd_a, 1'b1);
            chk($sformatf("holdoff quiet busy %0d", i), busy_a, 1'b0);
            tick();
        end

        // Every completed 8N1 frame as seen by the receiver, stop bit included.
        chk("rx count", rx_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < rx_q.size()) chk($sformatf("rx word %0d", i), rx_q[i], {1'b1, exp_words[i]});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
